riscv_fetch_unit: RTL

Parametrised instruction-fetch stage for the RISC-V pipeline, replacing the single-register IF stage. It issues pipelined requests to instruction memory over a request/ready plus in-order-response interface. Returned instructions and their PCs are buffered in a DEPTH-entry FIFO so the ID stage can stall without losing fetches. A branch redirect from MEM flushes the buffer and discards in-flight responses.

---
 rtl/riscv_fetch_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/riscv_fetch_unit.sv
// Pipelined instruction-fetch stage: in-order imem requests, DEPTH-entry {instr, pc} show-ahead buffer, branch flush.
// Optional RISCV_IF_MISALIGN_EN adds a registered misaligned-branch-target flag.
module riscv_fetch_unit #(
  parameter int unsigned           XLEN     = 32,
  parameter logic [XLEN-1:0]       RESET_PC = '0,
  parameter int unsigned           DEPTH    = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            id_ready_i,
  input  logic            take_branch_i,
  input  logic [XLEN-1:0] branch_addr_i
`ifdef RISCV_IF_MISALIGN_EN
  ,
  output logic            misaligned_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] instr_mem_d [DEPTH];
  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_d [DEPTH];

  logic            accept;
  logic            resp_ok;
  logic            push;
  logic            pop;
  logic [CW:0]     occ;
  logic [XLEN-1:0] target;

  assign target = {branch_addr_i[XLEN-1:2], 2'b00};

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    outst_d     = outst_q;
    drop_d      = drop_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;

    // Responses already owed to discarded requests still occupy no buffer slot.
    occ        = {1'b0, outst_q} - {1'b0, drop_q} + {1'b0, count_q};
    imem_req_o = !take_branch_i && (outst_q < DEPTH_C) && (occ < DEPTH_W);
    accept     = imem_req_o && imem_ready_i;
    resp_ok    = imem_rvalid_i && (outst_q != '0);
    push       = resp_ok && (drop_q == '0) && !take_branch_i;
    pop        = (count_q != '0) && id_ready_i && !take_branch_i;

    outst_d = outst_q + CW'(accept) - CW'(resp_ok);

    if (take_branch_i) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      drop_d     = outst_q - CW'(resp_ok);
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (resp_ok && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        instr_mem_d[wr_ptr_q] = imem_rdata_i;
        pc_mem_d[wr_ptr_q]    = resp_pc_q;
        wr_ptr_d              = wr_ptr_q + PW'(1);
        resp_pc_d             = resp_pc_q + XLEN'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
    end
  end

  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_mem_q[rd_ptr_q];
  assign pc_o          = pc_mem_q[rd_ptr_q];

`ifdef RISCV_IF_MISALIGN_EN
  logic misaligned_q, misaligned_d;

  always_comb begin
    misaligned_d = take_branch_i && (branch_addr_i[1:0] != 2'b00);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign misaligned_o = misaligned_q;
`else
  logic unused_branch_lsbs;
  assign unused_branch_lsbs = ^branch_addr_i[1:0];
`endif

endmodule
